stage_ctrl: RTL
===============

# stage_ctrl

Multi-cycle instruction sequencer for the single-issue core. Walks each instruction through IF/ID/EX/MEM/WB with one-hot stage enables and waits on the instruction- and data-memory ready handshakes. It decides when and where the PC register advances (pc_we plus npc), supports an external halt, traps on misaligned branch targets, and counts retired instructions.

## Interface
- RESET_PC, 32'h0000_0000, value driven on npc at reset; first fetch address
- clk  in  1  rising-edge clock
- rst_n  in  1  reset, synchronous, active-low
- pc  in  32  current PC from the PC register
- imem_ready  in  1  instruction word valid this cycle (IF handshake)
- dmem_ready  in  1  data access complete this cycle (MEM handshake)
- is_mem_op  in  1  decoded instruction needs MEM; valid in EX
- is_wb  in  1  decoded instruction writes the register file; valid in EX
- branch_taken  in  1  control transfer taken; valid in EX
- branch_target  in  32  transfer target; valid in EX
- halt  in  1  stop fetching at the next instruction boundary
- if_en, id_en, ex_en, mem_en, wb_en  out  1 each  stage enables, one-hot or all zero
- pc_we  out  1  single-cycle PC load strobe
- npc  out  32  next PC; meaningful when pc_we=1
- halted  out  1  sequencer parked in HALT
- trap  out  1  misaligned target detected; sticky until reset
- instret  out  32  retired-instruction count

## Operation
- States: START, IF, ID, EX, MEM, WB, HALT, TRAP. Stage enables are a Moore decode: if_en=1 in IF only, and so on. All enables are 0 in START, HALT and TRAP.
- START: lasts one cycle after reset release, then goes to IF (or HALT if halt=1). pc_we=0.
- IF: stays while imem_ready=0. Goes to ID on imem_ready=1.
- ID: goes to EX unconditionally.
- EX: latches is_mem_op, is_wb, branch_taken and branch_target into flags.
  - If branch_taken=1 and branch_target[1:0]!=0: goes to TRAP with no PC update.
  - Else if is_mem_op=1: goes to MEM.
  - Else if is_wb=1: goes to WB.
  - Else: retires now.
- MEM: stays while dmem_ready=0. On dmem_ready=1, goes to WB if the latched is_wb=1, otherwise retires.
- WB: retires unconditionally.
- Retire (combinational in the leaving cycle):
  - pc_we=1.
  - npc = latched taken ? latched target : pc+32'd4, modulo 2^32.
  - instret increments by 1 and wraps at 2^32.
  - Next state is HALT if halt=1, else IF.
- HALT: halted=1. Stays while halt=1; goes to IF on the first cycle halt=0.
- TRAP: trap=1. Terminal; only reset leaves it.
- Inputs outside their valid state are ignored:
  - decode/branch inputs are used only in EX
  - imem_ready only in IF
  - dmem_ready only in MEM
- halt is sampled only at retire, in START and in HALT. It never aborts an instruction in flight.

## Timing
- Reset (rst_n=0 at a rising edge):
  - state=START
  - instret=0, trap=0, halted=0
  - all enables 0, pc_we=0
  - latched flags cleared
  - npc=RESET_PC
- A mid-instruction reset discards the instruction with no pc_we.
- Cycles per instruction, with ready signals high on first sample:
  - plain (no MEM, no WB): 3 (IF, ID, EX)
  - ALU writeback: 4
  - store: 4
  - load: 5
- Each cycle of ready=0 adds one cycle in IF or MEM.
- pc_we is high for exactly one cycle per retired instruction, in the last state of that instruction. The PC register loads npc on that edge. The next IF sees the new pc.
- instret updates on the same edge as the PC load.
- halt and retire in the same cycle: the instruction retires (pc_we=1, instret+1), then HALT. halted rises the following cycle.
- halt=1 during reset release: START then HALT; no fetch.
- Misaligned target: TRAP is entered on the edge after EX. pc_we=0 and instret is unchanged. trap is high from the next cycle.

## Test plan
- Reset then plain op: release rst_n, pc=0, imem_ready=1, is_mem_op=is_wb=branch_taken=0.
  - Expect START, IF, ID, EX.
  - pc_we=1 in EX with npc=32'h4; instret=1 afterwards.
- Load with stalls: imem_ready low 2 cycles, is_mem_op=is_wb=1, dmem_ready low 3 cycles.
  - Expect 10 cycles from IF entry to the WB pc_we strobe.
  - mem_en held high throughout the MEM wait; npc=pc+4.
- Taken branch: in EX, branch_taken=1, branch_target=32'h0000_0100, is_wb=0.
  - Expect pc_we in EX with npc=32'h100.
  - A branch with is_wb=1 has pc_we in WB with the same npc.
- Misaligned branch: branch_target=32'h0000_0102.
  - Expect TRAP, trap=1, no pc_we, instret unchanged.
  - Trap persists for 20 cycles; rst_n=0 clears it.
- Halt: raise halt during ID.
  - Expect the instruction to retire, then halted=1 and enables 0 with halt held.
  - Drop halt: IF next cycle.
- Reset mid-MEM and wrap: assert rst_n=0 during a MEM stall; expect START, instret=0, no pc_we.
  - Separately, force pc=32'hFFFF_FFFC on a plain op; expect npc=32'h0.

Source files
------------

// File: rtl/stage_ctrl_if.sv
// rtl/stage_ctrl_if.sv - signal bundle between the core datapath and the stage sequencer
//
// Purpose: groups every non-clock signal of stage_ctrl.
//   slave  : sequencer side (stage_ctrl)
//   master : datapath / memory side
// Signals:
//   pc, imem_ready, dmem_ready, is_mem_op, is_wb,
//   branch_taken, branch_target, halt            datapath -> sequencer
//   if_en, id_en, ex_en, mem_en, wb_en, pc_we,
//   npc, halted, trap, instret                   sequencer -> datapath
interface stage_ctrl_if;
    logic [31:0] pc;
    logic        imem_ready;
    logic        dmem_ready;
    logic        is_mem_op;
    logic        is_wb;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic        halt;
    logic        if_en;
    logic        id_en;
    logic        ex_en;
    logic        mem_en;
    logic        wb_en;
    logic        pc_we;
    logic [31:0] npc;
    logic        halted;
    logic        trap;
    logic [31:0] instret;

    modport slave (
        input  pc, imem_ready, dmem_ready, is_mem_op, is_wb,
               branch_taken, branch_target, halt,
        output if_en, id_en, ex_en, mem_en, wb_en, pc_we, npc,
               halted, trap, instret
    );

    modport master (
        output pc, imem_ready, dmem_ready, is_mem_op, is_wb,
               branch_taken, branch_target, halt,
        input  if_en, id_en, ex_en, mem_en, wb_en, pc_we, npc,
               halted, trap, instret
    );
endinterface

// File: rtl/stage_ctrl.sv
// rtl/stage_ctrl.sv - multi-cycle IF/ID/EX/MEM/WB sequencer with PC update, halt and trap
//
// Purpose: walks one instruction at a time through the five stages, waits on
// the memory ready handshakes, strobes pc_we with npc at retire, counts
// retired instructions, parks on halt and traps on a misaligned taken target.
// Ports:
//   clk    rising-edge clock
//   rst_n  synchronous active-low reset
//   bus    stage_ctrl_if.slave (datapath inputs, stage enables, pc_we/npc,
//          halted, trap, instret)
module stage_ctrl #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic         clk,
    input  logic         rst_n,
    stage_ctrl_if.slave  bus
);
    typedef enum logic [2:0] {
        S_START, S_IF, S_ID, S_EX, S_MEM, S_WB, S_HALT, S_TRAP
    } state_t;

    state_t      r_state;
    state_t      w_next;
    logic        r_taken;
    logic        r_is_wb;
    logic [31:0] r_target;
    logic [31:0] r_instret;

    logic        w_misaligned;
    logic        w_retire;
    logic        w_taken;
    logic [31:0] w_target;

    assign w_misaligned = bus.branch_taken && (bus.branch_target[1:0] != 2'b00);

    // A retire in EX must use the live decode; MEM/WB retires use the copies
    // captured on the EX edge. Being in MEM already records is_mem_op.
    assign w_taken  = (r_state == S_EX) ? bus.branch_taken  : r_taken;
    assign w_target = (r_state == S_EX) ? bus.branch_target : r_target;

    always_comb begin
        w_retire = 1'b0;
        case (r_state)
            S_EX:    w_retire = !w_misaligned && !bus.is_mem_op && !bus.is_wb;
            S_MEM:   w_retire = bus.dmem_ready && !r_is_wb;
            S_WB:    w_retire = 1'b1;
            default: w_retire = 1'b0;
        endcase
    end

    // state register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_START;
        end else begin
            r_state <= w_next;
        end
    end

    // next-state logic
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_START: w_next = bus.halt ? S_HALT : S_IF;
            S_IF:    if (bus.imem_ready) w_next = S_ID;
            S_ID:    w_next = S_EX;
            S_EX: begin
                if (w_misaligned)       w_next = S_TRAP;
                else if (bus.is_mem_op) w_next = S_MEM;
                else if (bus.is_wb)     w_next = S_WB;
            end
            S_MEM:   if (bus.dmem_ready && r_is_wb) w_next = S_WB;
            S_WB:    w_next = S_WB;
            S_HALT:  if (!bus.halt) w_next = S_IF;
            S_TRAP:  w_next = S_TRAP;
            default: w_next = S_START;
        endcase
        // halt is only honoured at an instruction boundary
        if (w_retire) begin
            w_next = bus.halt ? S_HALT : S_IF;
        end
    end

    // EX-latched decode and retired-instruction counter
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_taken   <= 1'b0;
            r_is_wb   <= 1'b0;
            r_target  <= 32'h0;
            r_instret <= 32'h0;
        end else begin
            if (r_state == S_EX) begin
                r_taken  <= bus.branch_taken;
                r_is_wb  <= bus.is_wb;
                r_target <= bus.branch_target;
            end
            if (w_retire) begin
                r_instret <= r_instret + 32'd1;
            end
        end
    end

    // output decode
    always_comb begin
        bus.if_en  = (r_state == S_IF);
        bus.id_en  = (r_state == S_ID);
        bus.ex_en  = (r_state == S_EX);
        bus.mem_en = (r_state == S_MEM);
        bus.wb_en  = (r_state == S_WB);
        bus.halted = (r_state == S_HALT);
        bus.trap   = (r_state == S_TRAP);
        bus.pc_we  = w_retire;
        bus.npc    = RESET_PC;
        if (w_retire) begin
            bus.npc = w_taken ? w_target : bus.pc + 32'd4;
        end
        bus.instret = r_instret;
    end
endmodule
